key_search_ctrl: RTL and testbench

- Parametrised controller for a multi-lane brute-force key search.
- Each batch issues LANES consecutive candidate keys to external checker lanes, waits a fixed checker latency, then evaluates the returned match vector.
- Stops when a key matches (lowest lane wins) or when the programmed key range [key_lo, key_hi] is exhausted.
- Successor to the single-lane start/count/store/found sequencer; adds range limits, parallel lanes, checker-latency wait, exhaustion reporting and abort.

---
 rtl/key_search_ctrl.sv | 130 +++++++++++++
 tb/tb_key_search_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/key_search_ctrl.sv
// key_search_ctrl: multi-lane brute-force key search controller.
// Each batch issues LANES consecutive candidates, waits CHECK_LAT cycles,
// then scans the masked match vector (lowest lane wins) or advances.
module key_search_ctrl #(
    parameter int KEY_W     = 16,
    parameter int LANES     = 4,
    parameter int CHECK_LAT = 2,
    localparam int LW       = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [KEY_W-1:0] key_lo,
    input  logic [KEY_W-1:0] key_hi,
    input  logic [LANES-1:0] match,
    output logic [KEY_W-1:0] cand_base,
    output logic             cand_valid,
    output logic [LANES-1:0] lane_mask,
    output logic             busy,
    output logic             found,
    output logic             exhausted,
    output logic [KEY_W-1:0] found_key,
    output logic [LW-1:0]    found_lane
);

    localparam int CW = (CHECK_LAT > 2) ? $clog2(CHECK_LAT) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'((CHECK_LAT > 1) ? CHECK_LAT - 2 : 0);
    localparam bit HAS_WAIT = (CHECK_LAT > 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        EVAL    = 3'd3,
        FOUND   = 3'd4,
        EXHAUST = 3'd5
    } state_t;

    state_t           state, state_nx;
    logic [KEY_W-1:0] cur, limit;
    logic [CW-1:0]    wait_cnt;
    logic [LANES-1:0] mask_now, mask_q, q;
    logic [LW-1:0]    hit_lane;
    logic             hit, last_batch;

    // Per-lane range check in KEY_W+1 bits so the top of the key space never wraps.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign mask_now[i] = ({1'b0, cur} + (KEY_W+1)'(i)) <= {1'b0, limit};
    end

    // Mask is live during ISSUE and held afterwards for the EVAL scan.
    assign lane_mask  = (state == ISSUE) ? mask_now : mask_q;
    assign cand_base  = cur;
    assign cand_valid = (state == ISSUE);
    assign busy       = (state == ISSUE) || (state == WAIT) || (state == EVAL);
    assign found      = (state == FOUND);
    assign exhausted  = (state == EXHAUST);
    assign q          = match & lane_mask;
    assign hit        = |q;
    assign last_batch = ({1'b0, cur} + (KEY_W+1)'(LANES)) > {1'b0, limit};

    // Lowest set lane of the masked match vector.
    always_comb begin
        hit_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (q[i]) hit_lane = LW'(i);
        end
    end

    // Next-state logic; start low aborts or releases from any non-IDLE state.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (key_lo > key_hi) ? EXHAUST : ISSUE;
            ISSUE:   if (!start) state_nx = IDLE;
                     else        state_nx = HAS_WAIT ? WAIT : EVAL;
            WAIT:    if (!start) state_nx = IDLE;
                     else if (wait_cnt == '0) state_nx = EVAL;
            EVAL:    if (!start)        state_nx = IDLE;
                     else if (hit)      state_nx = FOUND;
                     else if (last_batch) state_nx = EXHAUST;
                     else               state_nx = ISSUE;
            FOUND,
            EXHAUST: if (!start) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Datapath: range latch, batch advance, latency counter and result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur        <= '0;
            limit      <= '0;
            wait_cnt   <= '0;
            mask_q     <= '0;
            found_key  <= '0;
            found_lane <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cur        <= key_lo;
                    limit      <= key_hi;
                    found_key  <= '0;
                    found_lane <= '0;
                end
                ISSUE: begin
                    wait_cnt <= WAIT_LOAD;
                    mask_q   <= mask_now;
                end
                WAIT: if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                EVAL: if (start) begin
                    if (hit) begin
                        found_key  <= cur + KEY_W'(hit_lane);
                        found_lane <= hit_lane;
                    end else if (!last_batch) begin
                        cur <= cur + KEY_W'(LANES);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_search_ctrl.sv
// Directed bench for key_search_ctrl (KEY_W=16, LANES=4, CHECK_LAT=2).
// Inputs change and outputs are checked on the falling edge.
module tb_key_search_ctrl;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] key_lo, key_hi;
    logic [3:0]  match;
    logic [15:0] cand_base, found_key;
    logic        cand_valid, busy, found, exhausted;
    logic [3:0]  lane_mask;
    logic [1:0]  found_lane;

    int checks = 0;
    int errors = 0;

    key_search_ctrl #(.KEY_W(16), .LANES(4), .CHECK_LAT(2)) dut (
        .clk(clk), .reset(reset), .start(start),
        .key_lo(key_lo), .key_hi(key_hi), .match(match),
        .cand_base(cand_base), .cand_valid(cand_valid), .lane_mask(lane_mask),
        .busy(busy), .found(found), .exhausted(exhausted),
        .found_key(found_key), .found_lane(found_lane)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Status snapshot {busy, cand_valid, found, exhausted}.
    function automatic logic [31:0] st();
        return {28'd0, busy, cand_valid, found, exhausted};
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; key_lo = '0; key_hi = '0; match = '0;
        @(negedge clk);
        chk("rst_status", st(), 32'b0000);
        chk("rst_base", cand_base, 32'h0);
        chk("rst_mask", lane_mask, 32'h0);
        chk("rst_fkey", found_key, 32'h0);
        chk("rst_flane", found_lane, 32'h0);
        reset = 1'b0;
        tick();

        // 1: lowest-lane match on second batch; match outside EVAL ignored
        key_lo = 16'h0010; key_hi = 16'h001F; start = 1'b1;
        tick();                                   // ISSUE base 0x10
        chk("t1_issue0", st(), 32'b1100);
        chk("t1_base0", cand_base, 32'h0010);
        chk("t1_mask0", lane_mask, 32'hF);
        match = 4'b1111;
        tick();                                   // WAIT
        chk("t1_wait0", st(), 32'b1000);
        match = 4'b0000;
        tick();                                   // EVAL batch 0
        chk("t1_eval0", st(), 32'b1000);
        tick();                                   // ISSUE base 0x14
        chk("t1_issue1", st(), 32'b1100);
        chk("t1_base1", cand_base, 32'h0014);
        tick();                                   // WAIT
        match = 4'b1100;
        tick();                                   // EVAL batch 1
        chk("t1_eval1", st(), 32'b1000);
        tick();                                   // FOUND
        chk("t1_found", st(), 32'b0010);
        chk("t1_fkey", found_key, 32'h0016);
        chk("t1_flane", found_lane, 32'h2);
        match = 4'b0001;
        tick(); tick();
        chk("t1_hold", st(), 32'b0010);
        chk("t1_hold_key", found_key, 32'h0016);
        start = 1'b0; match = 4'b0000;
        tick();
        chk("t1_release", st(), 32'b0000);

        // 2: no match over 0..7; pulses 3 cycles apart then exhausted
        key_lo = 16'h0000; key_hi = 16'h0007; start = 1'b1;
        tick();
        chk("t2_issue0", st(), 32'b1100);
        chk("t2_base0", cand_base, 32'h0000);
        tick();
        chk("t2_gap1", cand_valid, 32'h0);
        tick();
        chk("t2_gap2", cand_valid, 32'h0);
        tick();
        chk("t2_issue1", st(), 32'b1100);
        chk("t2_base1", cand_base, 32'h0004);
        tick(); tick();                           // EVAL batch 1
        chk("t2_eval1", st(), 32'b1000);
        tick();
        chk("t2_exh", st(), 32'b0001);
        tick();
        chk("t2_exh_hold", st(), 32'b0001);
        start = 1'b0;
        tick();
        chk("t2_release", st(), 32'b0000);

        // 3: partial last batch masks out lanes 2,3
        key_lo = 16'h0000; key_hi = 16'h0005; start = 1'b1;
        tick(); tick(); tick();                   // batch 0
        tick();                                   // ISSUE base 4
        chk("t3_base1", cand_base, 32'h0004);
        chk("t3_mask1", lane_mask, 32'h3);
        match = 4'b1100;
        tick();                                   // WAIT
        chk("t3_mask_held", lane_mask, 32'h3);
        tick(); tick();
        chk("t3_exh", st(), 32'b0001);
        start = 1'b0; match = 4'b0000;
        tick();

        // 4: top of key space, single batch, no wrap
        key_lo = 16'hFFFC; key_hi = 16'hFFFF; start = 1'b1;
        tick();
        chk("t4_base", cand_base, 32'hFFFC);
        chk("t4_mask", lane_mask, 32'hF);
        tick(); tick(); tick();
        chk("t4_exh", st(), 32'b0001);
        chk("t4_nowrap", cand_base, 32'hFFFC);
        start = 1'b0;
        tick();

        // 5: empty range goes straight to EXHAUST
        key_lo = 16'h0020; key_hi = 16'h001F; start = 1'b1;
        tick();
        chk("t5_exh", st(), 32'b0001);
        start = 1'b0;
        tick();

        // 6: abort during WAIT, reset during ISSUE, then clean rerun
        key_lo = 16'h0000; key_hi = 16'h001F; start = 1'b1;
        tick(); tick();                           // WAIT
        chk("t6_wait", st(), 32'b1000);
        start = 1'b0;
        tick();
        chk("t6_abort", st(), 32'b0000);
        key_lo = 16'h0100; key_hi = 16'h01FF; start = 1'b1;
        tick();
        chk("t6_issue", cand_base, 32'h0100);
        reset = 1'b1;
        #1;
        chk("t6_rst_status", st(), 32'b0000);
        chk("t6_rst_base", cand_base, 32'h0);
        chk("t6_rst_mask", lane_mask, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        key_lo = 16'h0040; key_hi = 16'h0041;
        tick();
        chk("t6_rerun_base", cand_base, 32'h0040);
        chk("t6_rerun_mask", lane_mask, 32'h3);
        match = 4'b0010;
        tick(); tick(); tick();
        chk("t6_found", st(), 32'b0010);
        chk("t6_fkey", found_key, 32'h0041);
        chk("t6_flane", found_lane, 32'h1);
        start = 1'b0; match = 4'b0000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
